booth_pp_reduce: RTL and testbench
==================================

Name: booth_pp_reduce

Overview:
- Pipelined partial-product reduction stage placed directly downstream of the radix-4 Booth encoder in the FP multiply/MAC datapath.
- Accepts the encoder's 13 partial products (49 bits each) under a valid/ready handshake.
- Compresses them with a 3:2 carry-save tree across two register stages, then resolves the product with a final carry-propagate add in a third stage.
- Exposes the carry-save pair for a later fused addend, plus the resolved 48-bit mantissa product and a pass-through tag.

Parameters:
PARM_MANT, 23, mantissa width excluding hidden bit; operands are PARM_MANT+1 bits
PP_W, 2*PARM_MANT+3 (49), partial-product width; derived, do not override
TAG_W, 8, width of opaque sideband carried alongside each operation

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush; drops all in-flight operations
valid_i  in  1  upstream partial products valid
ready_o  out  1  block can accept this cycle
pp_00_i .. pp_12_i  in  PP_W each  13 Booth partial products, sign-correction bits already embedded
tag_i  in  TAG_W  sideband, travels with operation
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
sum_o  out  PP_W  carry-save sum vector
carry_o  out  PP_W  carry-save carry vector (already shifted left by 1, bit 0 = 0)
prod_o  out  2*PARM_MANT+2 (48)  (sum_o+carry_o) mod 2^48 = MantA*MantB
tag_o  out  TAG_W  tag of the current result

Behaviour:
- Arithmetic: all sums are mod 2^PP_W. prod_o is the low 48 bits of the total. Carries out of bit PP_W-1 are discarded; this is required for the Booth sign-extension constants to cancel.
- Stage S1 (comb, then register): CSA levels 13->9->6. Register 6 vectors plus tag. Valid bit v1.
- Stage S2: CSA levels 6->4->3->2. Register sum/carry plus tag. Valid bit v2.
- Stage S3: 49-bit add of sum+carry. Register sum_o, carry_o, prod_o, tag_o. Valid bit v3 drives valid_o.
- Latency: 3 cycles from accepted input to valid_o with no stall. Throughput: 1 op/cycle.
- Handshake, per stage k: en_k = ~v_k | en_{k+1}, with en_4 = ready_i.
  - ready_o = en_1.
  - Input transfer when valid_i & ready_o.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
- Output stability: while valid_o & ~ready_i, every output holds stable, and v1/v2 hold once full.
- Data registers load only when their stage is enabled and upstream is valid. No data reset is needed except on outputs.
- Reset (rst_ni low, async):
  - v1, v2, v3 = 0.
  - sum_o, carry_o, prod_o, tag_o = 0; valid_o = 0.
  - ready_o goes to 1 once out of reset.
  - Reset mid-operation discards all in-flight data.
- flush_i: next edge clears v1..v3. An input presented in the flush cycle is discarded (not accepted), and ready_o is still reported. Flush has priority over transfer. Data registers may keep stale values, but valid_o = 0 the following cycle.
- Simultaneous pop and push with the pipe full and ready_i=1: everything advances; no bubble inserted.
- Full with ready_i=0 for N cycles: ready_o = 0 throughout. Result released the cycle ready_i rises, and ready_o rises in that same cycle (combinational path from ready_i).
- No X propagation: when a v_k is low, downstream outputs gate to registered values only.

Decomposition:
- Shared package mac_pkg:
  - PARM_MANT, PP_W, PP_CNT=13, PROD_W=48.
  - Localparam arrays of the per-level CSA grouping.
- One sub-module pp_csa32 (parameter W):
  - Bitwise full-adder row.
  - Outputs sum and carry, with carry shifted left by 1 and truncated to W.
  - Instantiated 11 times across S1/S2.
- S3 uses a plain "+"; synthesis chooses the adder.

Test Plan:
- A=0xFFFFFF, B=0xFFFFFF via the Booth encoder, ready_i=1 -> valid_o exactly 3 cycles later, prod_o=0xFFFFFE000001, (sum_o+carry_o) mod 2^48 matches.
- A=0x800000, B=0x800000, then A=0xC00000, B=0xA00000 back-to-back -> prod_o=0x400000000000 then 0x780000000000 on consecutive cycles, tags preserved in order.
- Issue 4 ops with ready_i=0 -> ready_o drops after 3 accepted, outputs stable. Raise ready_i -> ready_o=1 the same cycle, 4th op accepted, all 4 results delivered in order with no loss or duplication.
- Random 10k operand pairs, random valid_i/ready_i -> every prod_o equals the A*B reference, in order, matched by tag.
- flush_i pulsed with 3 ops in flight plus one presented -> valid_o=0 next cycle, no flushed tag ever emerges, next op after flush completes correctly.
- rst_ni asserted asynchronously mid-stream (between clock edges) -> valid_o, prod_o, sum_o, carry_o, tag_o =0 immediately. After release, ready_o=1 and the first new op completes in 3 cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths and carry-save tree shape for the FP multiply/MAC datapath.
// The level tables give the CSA count and vector count at each tree level.
package mac_pkg;
  localparam int PARM_MANT = 23;
  localparam int PP_W      = 2*PARM_MANT+3;
  localparam int PP_CNT    = 13;
  localparam int PROD_W    = 2*PARM_MANT+2;
  localparam int TAG_W     = 8;
  localparam int LVL_N     = 5;
  localparam int LVL_CSA [LVL_N] = '{4, 3, 2, 1, 1};
  localparam int LVL_OUT [LVL_N] = '{9, 6, 4, 3, 2};
endpackage

// File: rtl/booth_pp_reduce_if.sv
// Partial-product reduction bus: Booth operands in, carry-save pair and
// resolved product out, each side with its own valid/ready pair.
interface booth_pp_reduce_if;
  import mac_pkg::*;
  logic              valid_i;
  logic              ready_o;
  logic [PP_W-1:0]   pp_00_i, pp_01_i, pp_02_i, pp_03_i, pp_04_i;
  logic [PP_W-1:0]   pp_05_i, pp_06_i, pp_07_i, pp_08_i, pp_09_i;
  logic [PP_W-1:0]   pp_10_i, pp_11_i, pp_12_i;
  logic [TAG_W-1:0]  tag_i;
  logic              valid_o;
  logic              ready_i;
  logic [PP_W-1:0]   sum_o;
  logic [PP_W-1:0]   carry_o;
  logic [PROD_W-1:0] prod_o;
  logic [TAG_W-1:0]  tag_o;

  modport master (
    output valid_i, tag_i, ready_i,
    output pp_00_i, pp_01_i, pp_02_i, pp_03_i, pp_04_i,
    output pp_05_i, pp_06_i, pp_07_i, pp_08_i, pp_09_i,
    output pp_10_i, pp_11_i, pp_12_i,
    input  ready_o, valid_o, sum_o, carry_o, prod_o, tag_o
  );

  modport slave (
    input  valid_i, tag_i, ready_i,
    input  pp_00_i, pp_01_i, pp_02_i, pp_03_i, pp_04_i,
    input  pp_05_i, pp_06_i, pp_07_i, pp_08_i, pp_09_i,
    input  pp_10_i, pp_11_i, pp_12_i,
    output ready_o, valid_o, sum_o, carry_o, prod_o, tag_o
  );
endinterface

// File: rtl/pp_csa32.sv
// One row of full adders: three vectors in, sum and weight-2 carry out.
// The carry comes back pre-shifted so both outputs share the same weight.
module pp_csa32 #(
  parameter int W = 49
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);
  logic [W-2:0] w_maj;

  assign sum_o = a_i ^ b_i ^ c_i;
  assign w_maj = (a_i[W-2:0] & b_i[W-2:0])
               | (a_i[W-2:0] & c_i[W-2:0])
               | (b_i[W-2:0] & c_i[W-2:0]);
  assign carry_o = {w_maj, 1'b0};
endmodule

// File: rtl/booth_pp_reduce.sv
// Three-stage reduction of 13 Booth partial products: CSA 13->6, CSA 6->2,
// then a carry-propagate add. Elastic pipe, bubbles collapse under stall.
module booth_pp_reduce
  import mac_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  booth_pp_reduce_if.slave bus
);
  typedef logic [PP_W-1:0] vec_t;

  logic w_en1, w_en2, w_en3;
  logic r_v1, r_v2, r_v3;

  vec_t w_pp [PP_CNT];
  vec_t w_l1 [LVL_OUT[0]];
  vec_t w_l2 [LVL_OUT[1]];
  vec_t r_s1 [LVL_OUT[1]];
  vec_t w_l3 [LVL_OUT[2]];
  vec_t w_l4 [LVL_OUT[3]];
  vec_t w_s2_sum, w_s2_car;
  vec_t r_s2_sum, r_s2_car;
  vec_t r_sum, r_car;
  logic [PROD_W-1:0] w_prod, r_prod;
  logic [TAG_W-1:0]  r_t1, r_t2, r_tag;

  assign w_pp = '{bus.pp_00_i, bus.pp_01_i, bus.pp_02_i, bus.pp_03_i,
                  bus.pp_04_i, bus.pp_05_i, bus.pp_06_i, bus.pp_07_i,
                  bus.pp_08_i, bus.pp_09_i, bus.pp_10_i, bus.pp_11_i,
                  bus.pp_12_i};

  // A stage may take new data when empty or when its content moves on.
  assign w_en3 = ~r_v3 | bus.ready_i;
  assign w_en2 = ~r_v2 | w_en3;
  assign w_en1 = ~r_v1 | w_en2;

  for (genvar i = 0; i < LVL_CSA[0]; i++) begin : g_l1
    pp_csa32 #(.W(PP_W)) u_csa (
      .a_i(w_pp[3*i]), .b_i(w_pp[3*i+1]), .c_i(w_pp[3*i+2]),
      .sum_o(w_l1[2*i]), .carry_o(w_l1[2*i+1])
    );
  end
  assign w_l1[LVL_OUT[0]-1] = w_pp[PP_CNT-1];

  for (genvar i = 0; i < LVL_CSA[1]; i++) begin : g_l2
    pp_csa32 #(.W(PP_W)) u_csa (
      .a_i(w_l1[3*i]), .b_i(w_l1[3*i+1]), .c_i(w_l1[3*i+2]),
      .sum_o(w_l2[2*i]), .carry_o(w_l2[2*i+1])
    );
  end

  for (genvar i = 0; i < LVL_CSA[2]; i++) begin : g_l3
    pp_csa32 #(.W(PP_W)) u_csa (
      .a_i(r_s1[3*i]), .b_i(r_s1[3*i+1]), .c_i(r_s1[3*i+2]),
      .sum_o(w_l3[2*i]), .carry_o(w_l3[2*i+1])
    );
  end

  pp_csa32 #(.W(PP_W)) u_l4 (
    .a_i(w_l3[0]), .b_i(w_l3[1]), .c_i(w_l3[2]),
    .sum_o(w_l4[0]), .carry_o(w_l4[1])
  );
  assign w_l4[2] = w_l3[3];

  pp_csa32 #(.W(PP_W)) u_l5 (
    .a_i(w_l4[0]), .b_i(w_l4[1]), .c_i(w_l4[2]),
    .sum_o(w_s2_sum), .carry_o(w_s2_car)
  );

  // Bit PP_W-1 only feeds the sign constants, which cancel mod 2^PROD_W.
  assign w_prod = r_s2_sum[PROD_W-1:0] + r_s2_car[PROD_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (flush_i) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_en1) r_v1 <= bus.valid_i;
      if (w_en2) r_v2 <= r_v1;
      if (w_en3) r_v3 <= r_v2;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_en1 && bus.valid_i) begin
      r_s1 <= w_l2;
      r_t1 <= bus.tag_i;
    end
    if (w_en2 && r_v1) begin
      r_s2_sum <= w_s2_sum;
      r_s2_car <= w_s2_car;
      r_t2     <= r_t1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sum  <= '0;
      r_car  <= '0;
      r_prod <= '0;
      r_tag  <= '0;
    end else if (w_en3 && r_v2) begin
      r_sum  <= r_s2_sum;
      r_car  <= r_s2_car;
      r_prod <= w_prod;
      r_tag  <= r_t2;
    end
  end

  assign bus.ready_o = w_en1;
  assign bus.valid_o = r_v3;
  assign bus.sum_o   = r_sum;
  assign bus.carry_o = r_car;
  assign bus.prod_o  = r_prod;
  assign bus.tag_o   = r_tag;
endmodule

// File: tb/tb_booth_pp_reduce.sv
// Bench for booth_pp_reduce: Booth-encodes operands, scoreboards A*B by
// order and tag, and checks handshake, stall, flush and reset behaviour.
module tb_booth_pp_reduce;
  import mac_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i = 1'b0;

  booth_pp_reduce_if bus();

  booth_pp_reduce dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .flush_i(flush_i),
    .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  tag;
    logic [47:0] prod;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int n_pop = 0;
  exp_t q[$];
  logic [23:0] cur_a = '0;
  logic [23:0] cur_b = '0;
  logic have_prev = 1'b0;
  logic [48:0] p_sum, p_car;
  logic [47:0] p_prod;
  logic [7:0]  p_tag;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Radix-4 digit i uses b[2i+1], b[2i], b[2i-1]; product term d*A*4^i.
  function automatic logic [48:0] booth_pp(input logic [23:0] a,
                                           input logic [23:0] b,
                                           input int i);
    logic [26:0] bx;
    longint d, v;
    bx = {2'b00, b, 1'b0};
    d = longint'(bx[2*i+1]) + longint'(bx[2*i]) - 2 * longint'(bx[2*i+2]);
    v = (d * longint'(a)) <<< (2*i);
    return v[48:0];
  endfunction

  function automatic logic [47:0] ref_mul(input logic [23:0] a,
                                          input logic [23:0] b);
    longint v;
    v = longint'(a) * longint'(b);
    return v[47:0];
  endfunction

  function automatic logic [23:0] rnd();
    case ($urandom_range(7))
      0: return 24'h000000;
      1: return 24'hFFFFFF;
      2: return 24'h800000;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic put(input logic v, input logic [23:0] a,
                     input logic [23:0] b, input logic [7:0] t);
    cur_a = a;
    cur_b = b;
    bus.valid_i = v;
    bus.tag_i = t;
    bus.pp_00_i = booth_pp(a, b, 0);
    bus.pp_01_i = booth_pp(a, b, 1);
    bus.pp_02_i = booth_pp(a, b, 2);
    bus.pp_03_i = booth_pp(a, b, 3);
    bus.pp_04_i = booth_pp(a, b, 4);
    bus.pp_05_i = booth_pp(a, b, 5);
    bus.pp_06_i = booth_pp(a, b, 6);
    bus.pp_07_i = booth_pp(a, b, 7);
    bus.pp_08_i = booth_pp(a, b, 8);
    bus.pp_09_i = booth_pp(a, b, 9);
    bus.pp_10_i = booth_pp(a, b, 10);
    bus.pp_11_i = booth_pp(a, b, 11);
    bus.pp_12_i = booth_pp(a, b, 12);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.valid_o && n < 10) begin
      step();
      n++;
    end
  endtask

  // Compare process: decides each transfer just before the coming edge.
  always @(negedge clk_i) begin
    exp_t e;
    logic [48:0] sc;
    if (!rst_ni) begin
      q.delete();
      have_prev = 1'b0;
    end else begin
      chk("ready_o", 64'(bus.ready_o), 64'((q.size() < 3) || bus.ready_i));
      if (have_prev) begin
        chk("hold_valid", 64'(bus.valid_o), 64'(1));
        chk("hold_sum", 64'(bus.sum_o), 64'(p_sum));
        chk("hold_carry", 64'(bus.carry_o), 64'(p_car));
        chk("hold_prod", 64'(bus.prod_o), 64'(p_prod));
        chk("hold_tag", 64'(bus.tag_o), 64'(p_tag));
      end
      if (bus.valid_o) begin
        chk("spurious_valid", 64'(q.size() > 0), 64'(1));
      end
      if (bus.valid_o && bus.ready_i && q.size() > 0) begin
        e = q.pop_front();
        n_pop++;
        sc = bus.sum_o + bus.carry_o;
        chk("tag", 64'(bus.tag_o), 64'(e.tag));
        chk("prod", 64'(bus.prod_o), 64'(e.prod));
        chk("sum_carry", 64'(sc[47:0]), 64'(e.prod));
        chk("carry_lsb", 64'(bus.carry_o[0]), 64'(0));
      end
      have_prev = bus.valid_o && !bus.ready_i && !flush_i;
      p_sum = bus.sum_o;
      p_car = bus.carry_o;
      p_prod = bus.prod_o;
      p_tag = bus.tag_o;
      if (flush_i) q.delete();
      if (bus.valid_i && bus.ready_o && !flush_i) begin
        e.tag = bus.tag_i;
        e.prod = ref_mul(cur_a, cur_b);
        q.push_back(e);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, sent, cyc, pops0;
    logic pend;
    bus.ready_i = 1'b1;
    put(1'b0, 24'h0, 24'h0, 8'h00);
    repeat (2) step();

    chk("rst_valid", 64'(bus.valid_o), 64'(0));
    chk("rst_prod", 64'(bus.prod_o), 64'(0));
    chk("rst_sum", 64'(bus.sum_o), 64'(0));
    chk("rst_carry", 64'(bus.carry_o), 64'(0));
    chk("rst_tag", 64'(bus.tag_o), 64'(0));
    chk("rst_ready", 64'(bus.ready_o), 64'(1));
    rst_ni = 1'b1;
    step();

    chk("model_ff", 64'(ref_mul(24'hFFFFFF, 24'hFFFFFF)), 64'h0000FFFFFE000001);
    put(1'b1, 24'hFFFFFF, 24'hFFFFFF, 8'h11);
    step();
    put(1'b0, 24'h0, 24'h0, 8'h00);
    wait_valid(n);
    chk("latency_ff", 64'(n), 64'(3));
    chk("prod_ff", 64'(bus.prod_o), 64'h0000FFFFFE000001);
    chk("tag_ff", 64'(bus.tag_o), 64'h11);
    repeat (3) step();

    put(1'b1, 24'h800000, 24'h800000, 8'h21);
    step();
    put(1'b1, 24'hC00000, 24'hA00000, 8'h22);
    step();
    put(1'b0, 24'h0, 24'h0, 8'h00);
    step();
    chk("b2b_v0", 64'(bus.valid_o), 64'(1));
    chk("b2b_p0", 64'(bus.prod_o), 64'h0000400000000000);
    chk("b2b_t0", 64'(bus.tag_o), 64'h21);
    step();
    chk("b2b_v1", 64'(bus.valid_o), 64'(1));
    chk("b2b_p1", 64'(bus.prod_o), 64'h0000780000000000);
    chk("b2b_t1", 64'(bus.tag_o), 64'h22);
    repeat (3) step();

    bus.ready_i = 1'b0;
    pops0 = n_pop;
    for (int k = 0; k < 3; k++) begin
      put(1'b1, rnd(), rnd(), 8'(8'h30 + k));
      step();
    end
    put(1'b1, 24'h123456, 24'h00ABCD, 8'h33);
    for (int k = 0; k < 4; k++) begin
      chk("stall_ready", 64'(bus.ready_o), 64'(0));
      step();
    end
    bus.ready_i = 1'b1;
    #1;
    chk("release_ready", 64'(bus.ready_o), 64'(1));
    step();
    put(1'b0, 24'h0, 24'h0, 8'h00);
    repeat (6) step();
    chk("stall_pops", 64'(n_pop - pops0), 64'(4));
    chk("stall_empty", 64'(q.size()), 64'(0));

    sent = 0;
    cyc = 0;
    pend = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      bus.ready_i = ($urandom_range(3) != 0);
      if (!pend && $urandom_range(3) != 0) begin
        put(1'b1, rnd(), rnd(), 8'(sent));
        pend = 1'b1;
      end
      #2;
      if (pend && bus.ready_o) begin
        pend = 1'b0;
        sent++;
      end
      step();
      cyc++;
      if (!pend) put(1'b0, cur_a, cur_b, bus.tag_i);
    end
    chk("random_sent", 64'(sent), 64'(10000));
    bus.ready_i = 1'b1;
    repeat (6) step();
    chk("random_drain", 64'(q.size()), 64'(0));

    bus.ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      put(1'b1, rnd(), rnd(), 8'(8'hA0 + k));
      step();
    end
    put(1'b1, rnd(), rnd(), 8'hA3);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    put(1'b0, 24'h0, 24'h0, 8'h00);
    chk("flush_valid", 64'(bus.valid_o), 64'(0));
    bus.ready_i = 1'b1;
    put(1'b1, 24'h123456, 24'h654321, 8'hB0);
    step();
    put(1'b0, 24'h0, 24'h0, 8'h00);
    wait_valid(n);
    chk("flush_latency", 64'(n), 64'(3));
    chk("flush_tag", 64'(bus.tag_o), 64'hB0);
    chk("flush_prod", 64'(bus.prod_o), 64'(ref_mul(24'h123456, 24'h654321)));
    repeat (3) step();

    for (int k = 0; k < 5; k++) begin
      put(1'b1, rnd(), rnd(), 8'(8'hC0 + k));
      step();
    end
    chk("pre_rst_valid", 64'(bus.valid_o), 64'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.valid_o), 64'(0));
    chk("arst_prod", 64'(bus.prod_o), 64'(0));
    chk("arst_sum", 64'(bus.sum_o), 64'(0));
    chk("arst_carry", 64'(bus.carry_o), 64'(0));
    chk("arst_tag", 64'(bus.tag_o), 64'(0));
    put(1'b0, 24'h0, 24'h0, 8'h00);
    repeat (2) step();
    rst_ni = 1'b1;
    #1;
    chk("post_rst_ready", 64'(bus.ready_o), 64'(1));
    put(1'b1, 24'h000003, 24'h000005, 8'hD0);
    step();
    put(1'b0, 24'h0, 24'h0, 8'h00);
    wait_valid(n);
    chk("post_rst_latency", 64'(n), 64'(3));
    chk("post_rst_prod", 64'(bus.prod_o), 64'hF);
    chk("post_rst_tag", 64'(bus.tag_o), 64'hD0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
